// File: rtl/tx_frame_seq.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tx_frame_seq: steps the ADC byte mux through ch0/ch1 MSB/LSB and hands     |
// | each latched byte to the UART TX with a start/done handshake. Rev 1.0     |
// +---------------------------------------------------------------------------+

module tx_frame_seq #(
    parameter int Width     = 8,
    parameter int NBytes    = 4,
    parameter int GapCycles = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [Width-1:0] data_i,
    input  logic             tx_done_i,
    output logic [1:0]       sel_o,
    output logic [Width-1:0] tx_data_o,
    output logic             tx_start_o,
    output logic             busy_o,
    output logic             frame_done_o,
    output logic             overrun_o
);

    localparam int CntW = (GapCycles > 0) ? $clog2(GapCycles + 1) : 1;
    localparam logic [1:0] LastIdx = 2'(NBytes - 1);
    localparam logic [CntW-1:0] GapLoad = (GapCycles > 0) ? CntW'(GapCycles - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEL  = 3'd1,
        S_LOAD = 3'd2,
        S_WAIT = 3'd3,
        S_GAP  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t            state_q;
    logic [1:0]        idx_q;
    logic [Width-1:0]  tx_data_q;
    logic              tx_start_q;
    logic              busy_q;
    logic              frame_done_q;
    logic              overrun_q;
    logic [CntW-1:0]   gap_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            idx_q        <= 2'd0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            gap_cnt_q    <= '0;
        end else begin
            tx_start_q   <= 1'b0;
            frame_done_q <= 1'b0;

            // A start outside IDLE (DONE included) never restarts the frame.
            if (start_i && (state_q != S_IDLE)) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    idx_q <= 2'd0;
                    if (start_i) begin
                        busy_q  <= 1'b1;
                        state_q <= S_SEL;
                    end
                end
                S_SEL: begin
                    state_q <= S_LOAD;
                end
                S_LOAD: begin
                    tx_data_q  <= data_i;
                    tx_start_q <= 1'b1;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    if (tx_done_i) begin
                        if (idx_q == LastIdx) begin
                            state_q <= S_DONE;
                        end else begin
                            idx_q <= idx_q + 2'd1;
                            if (GapCycles == 0) begin
                                state_q <= S_SEL;
                            end else begin
                                gap_cnt_q <= GapLoad;
                                state_q   <= S_GAP;
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == '0) begin
                        state_q <= S_SEL;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 1'b1;
                    end
                end
                S_DONE: begin
                    frame_done_q <= 1'b1;
                    busy_q       <= 1'b0;
                    idx_q        <= 2'd0;
                    state_q      <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign sel_o        = idx_q;
    assign tx_data_o    = tx_data_q;
    assign tx_start_o   = tx_start_q;
    assign busy_o       = busy_q;
    assign frame_done_o = frame_done_q;
    assign overrun_o    = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_tx_frame_seq.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_tx_frame_seq: three sequencer instances (G=2/N=4, G=0/N=4, G=2/N=2)    |
// | driven by mux/UART models and checked against a frame-level model. Rev 1.0|
// +---------------------------------------------------------------------------+

module tb_tx_frame_seq;

    localparam int NI          = 3;
    localparam int G_T  [NI]   = '{2, 0, 2};
    localparam int NB_T [NI]   = '{4, 4, 2};
    localparam int BUDGET      = 300;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NI-1:0]           start;
    logic [NI-1:0]           done_inj;
    logic [NI-1:0]           uart_done;
    logic [NI-1:0]           tx_done;
    logic [NI-1:0][7:0]      data;
    logic [NI-1:0][1:0]      sel;
    logic [NI-1:0][7:0]      txd;
    logic [NI-1:0]           txs;
    logic [NI-1:0]           busy;
    logic [NI-1:0]           fd;
    logic [NI-1:0]           ovr;

    logic [7:0]              tbl [NI][4];
    int                      uart_dly [NI];
    int                      due [NI];
    int                      midx [NI];
    int                      last_done [NI];
    bit                      waiting [NI];
    int                      start_cnt [NI];
    int                      fd_cnt [NI];
    int                      cyc = 0;
    int                      n_tests = 0;
    int                      n_fail = 0;

    assign tx_done = uart_done | done_inj;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        tx_frame_seq #(
            .Width     (8),
            .NBytes    (NB_T[k]),
            .GapCycles (G_T[k])
        ) u_dut (
            .clk_i        (clk),
            .rst_ni       (rst_n),
            .start_i      (start[k]),
            .data_i       (data[k]),
            .tx_done_i    (tx_done[k]),
            .sel_o        (sel[k]),
            .tx_data_o    (txd[k]),
            .tx_start_o   (txs[k]),
            .busy_o       (busy[k]),
            .frame_done_o (fd[k]),
            .overrun_o    (ovr[k])
        );
    end

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Byte multiplexer: presents the channel byte chosen by sel_o.
    always_comb begin
        for (int k = 0; k < NI; k++) data[k] = tbl[k][sel[k]];
    end

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s [dut%0d]: observed %0h, expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic timeout(input string tag, input int k);
        n_tests++;
        n_fail++;
        $error("FAIL %s [dut%0d]: observed no event, expected one within %0d cycles", tag, k, BUDGET);
    endtask

    // UART model: tx_done one cycle-pulse uart_dly cycles after tx_start.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < NI; k++) uart_done[k] = rst_n && (cyc == due[k]);
    end

    // Frame-level reference: byte b of a frame is tbl[k][b] on select b,
    // next byte G+3 cycles after the accepted done, frame_done 2 cycles after the last.
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (!rst_n) begin
                midx[k]      = 0;
                waiting[k]   = 1'b0;
                last_done[k] = -1000;
                due[k]       = -1;
            end else begin
                if (txs[k]) begin
                    chk("sel_order", k, sel[k], midx[k]);
                    chk("byte_data", k, txd[k], tbl[k][midx[k] % 4]);
                    chk("busy_in_frame", k, busy[k], 1);
                    if (midx[k] > 0) chk("done_to_start", k, cyc - last_done[k], G_T[k] + 3);
                    midx[k]++;
                    waiting[k] = 1'b1;
                    start_cnt[k]++;
                    if (!tx_done[k]) due[k] = cyc + uart_dly[k];
                end
                if (tx_done[k] && waiting[k]) begin
                    waiting[k]   = 1'b0;
                    last_done[k] = cyc;
                end
                if (fd[k]) begin
                    chk("bytes_before_done", k, midx[k], NB_T[k]);
                    chk("done_latency", k, cyc - last_done[k], 2);
                    chk("busy_fall", k, busy[k], 0);
                    midx[k] = 0;
                    fd_cnt[k]++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_txs(input int k, output int t);
        t = -1;
        for (int n = 0; n < BUDGET; n++) begin
            @(negedge clk);
            if (txs[k]) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) timeout("wait_tx_start", k);
    endtask

    task automatic wait_done(input int k);
        bit seen = 1'b0;
        for (int n = 0; n < BUDGET; n++) begin
            @(negedge clk);
            if (tx_done[k]) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) timeout("wait_tx_done", k);
    endtask

    task automatic wait_fd(input int k);
        bit seen = 1'b0;
        for (int n = 0; n < BUDGET * 4; n++) begin
            @(negedge clk);
            if (fd[k]) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) timeout("wait_frame_done", k);
    endtask

    task automatic check_reset(input string tag);
        for (int k = 0; k < NI; k++)
            chk(tag, k, {sel[k], txd[k], txs[k], busy[k], fd[k], ovr[k]}, 0);
    endtask

    task automatic randomize_tbl(input int k);
        for (int b = 0; b < 4; b++) tbl[k][b] = 8'($urandom);
    endtask

    // Called at the start of a cycle with instance k idle; returns one cycle after frame_done.
    task automatic run_frame(input int k);
        int sc = start_cnt[k];
        int fc = fd_cnt[k];
        start[k] = 1'b1;
        tick();
        start[k] = 1'b0;
        wait_fd(k);
        tick();
        chk("frame_byte_count", k, start_cnt[k] - sc, NB_T[k]);
        chk("frame_done_count", k, fd_cnt[k] - fc, 1);
        chk("data_hold", k, txd[k], tbl[k][NB_T[k] - 1]);
    endtask

    initial begin
        int t, s, sc, fc;
        rst_n    = 1'b0;
        start    = '0;
        done_inj = '0;
        for (int k = 0; k < NI; k++) begin
            uart_dly[k]  = 10;
            start_cnt[k] = 0;
            fd_cnt[k]    = 0;
            randomize_tbl(k);
        end

        repeat (6) begin
            tick();
            start    = 3'($urandom);
            done_inj = 3'($urandom);
            @(negedge clk);
            check_reset("reset_value");
        end
        tick();
        start    = '0;
        done_inj = '0;
        for (int k = 0; k < NI; k++) begin
            tbl[k][0] = 8'hA1; tbl[k][1] = 8'hB2; tbl[k][2] = 8'hC3; tbl[k][3] = 8'hD4;
        end
        rst_n = 1'b1;
        tick();
        tick();

        // First frame: latency from the sampling edge, then the fixed byte table.
        sc = start_cnt[0];
        fc = fd_cnt[0];
        s  = cyc;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        @(negedge clk);
        chk("busy_after_start", 0, busy[0], 1);
        wait_txs(0, t);
        chk("start_latency", 0, t - (s + 1), 2);
        wait_fd(0);
        tick();
        chk("frame_byte_count", 0, start_cnt[0] - sc, 4);
        chk("frame_done_count", 0, fd_cnt[0] - fc, 1);
        chk("no_overrun", 0, ovr[0], 0);

        run_frame(1);
        run_frame(2);

        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < NI; k++) begin
                randomize_tbl(k);
                uart_dly[k] = $urandom_range(1, 12);
                repeat ($urandom_range(0, 4)) tick();
                run_frame(k);
            end
        end

        // Overrun: extra start during byte 2 must not disturb the frame.
        uart_dly[0] = 10;
        randomize_tbl(0);
        sc = start_cnt[0];
        fc = fd_cnt[0];
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        repeat (3) wait_txs(0, t);
        tick();
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        wait_fd(0);
        tick();
        chk("overrun_frame_bytes", 0, start_cnt[0] - sc, 4);
        chk("overrun_frame_done", 0, fd_cnt[0] - fc, 1);
        chk("overrun_set", 0, ovr[0], 1);
        randomize_tbl(0);
        run_frame(0);
        chk("overrun_sticky", 0, ovr[0], 1);

        // Spurious done in IDLE.
        sc = start_cnt[0];
        done_inj[0] = 1'b1;
        tick();
        done_inj[0] = 1'b0;
        repeat (6) tick();
        chk("idle_done_busy", 0, busy[0], 0);
        chk("idle_done_no_start", 0, start_cnt[0] - sc, 0);

        // Spurious done in the first GAP cycle.
        sc = start_cnt[0];
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        wait_done(0);
        tick();
        done_inj[0] = 1'b1;
        tick();
        done_inj[0] = 1'b0;
        wait_fd(0);
        tick();
        chk("gap_done_bytes", 0, start_cnt[0] - sc, 4);

        // Done coincident with tx_start (third cycle after the start pulse).
        for (int k = 0; k < 2; k++) begin
            sc = start_cnt[k];
            start[k] = 1'b1;
            tick();
            start[k] = 1'b0;
            tick();
            tick();
            done_inj[k] = 1'b1;
            tick();
            done_inj[k] = 1'b0;
            wait_fd(k);
            tick();
            chk("coincident_done_bytes", k, start_cnt[k] - sc, 4);
        end

        // Reset during WAIT of byte 1 aborts without frame_done.
        uart_dly[0] = 10;
        fc = fd_cnt[0];
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        repeat (2) wait_txs(0, t);
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        check_reset("midframe_reset");
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("abort_no_frame_done", 0, fd_cnt[0] - fc, 0);
        randomize_tbl(0);
        run_frame(0);
        chk("overrun_cleared", 0, ovr[0], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
